// File: rtl/button_conditioner.sv
// button_conditioner: synchronizes and debounces two raw buttons, then turns each
// press into a one-cycle step pulse with optional auto-repeat and a both-held lockout.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_DELAY    = 16,
   parameter int REPEAT_PERIOD   = 8,
   parameter bit REPEAT_EN       = 1'b1
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_increase_duty,
   input  logic       i_decrease_duty,
   output logic       o_inc_pulse,
   output logic       o_dec_pulse,
   output logic [1:0] o_held
);
   localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = $clog2(RMAX + 1);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);
   typedef enum logic [1:0] {IDLE, HOLD_WAIT, REPEAT} state_t;
   logic [1:0]         sync_a, sync_b, lvl, lvl_d, pulse_d;
   logic [1:0][DW-1:0] db_cnt, db_cnt_d;
   logic [1:0][RW-1:0] rp_cnt, rp_cnt_d;
   state_t             state [2];
   state_t             state_d [2];
   logic               lock;
   always_comb begin
      lvl_d    = lvl;
      db_cnt_d = db_cnt;
      state_d  = state;
      rp_cnt_d = rp_cnt;
      pulse_d  = '0;
      for (int c = 0; c < 2; c++) begin
         lvl_d[c]    = (sync_b[c] != lvl[c] && db_cnt[c] == DB_LAST) ? sync_b[c] : lvl[c];
         db_cnt_d[c] = (sync_b[c] == lvl[c] || db_cnt[c] == DB_LAST) ? '0 : db_cnt[c] + 1'b1;
      end
      // Lockout also covers the edge that leaves it, so the survivor restarts from zero.
      lock = (&lvl) | (&lvl_d);
      for (int c = 0; c < 2; c++) begin
         if (lvl[c] && !lvl_d[c]) begin
            state_d[c]  = IDLE;
            rp_cnt_d[c] = '0;
         end else if (lock && lvl_d[c]) begin
            state_d[c]  = HOLD_WAIT;
            rp_cnt_d[c] = '0;
         end else begin
            case (state[c])
               IDLE: if (lvl_d[c]) begin
                  state_d[c]  = HOLD_WAIT;
                  rp_cnt_d[c] = '0;
                  pulse_d[c]  = 1'b1;
               end
               HOLD_WAIT: if (REPEAT_EN && rp_cnt[c] == RD_LAST) begin
                  state_d[c]  = REPEAT;
                  rp_cnt_d[c] = '0;
                  pulse_d[c]  = 1'b1;
               end else begin
                  rp_cnt_d[c] = (rp_cnt[c] == RD_LAST) ? rp_cnt[c] : rp_cnt[c] + 1'b1;
               end
               default: if (rp_cnt[c] == RP_LAST) begin
                  rp_cnt_d[c] = '0;
                  pulse_d[c]  = 1'b1;
               end else begin
                  rp_cnt_d[c] = rp_cnt[c] + 1'b1;
               end
            endcase
         end
      end
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_a      <= '0;
         sync_b      <= '0;
         lvl         <= '0;
         db_cnt      <= '0;
         rp_cnt      <= '0;
         state[0]    <= IDLE;
         state[1]    <= IDLE;
         o_inc_pulse <= 1'b0;
         o_dec_pulse <= 1'b0;
      end else begin
         sync_a      <= {i_decrease_duty, i_increase_duty};
         sync_b      <= sync_a;
         lvl         <= lvl_d;
         db_cnt      <= db_cnt_d;
         rp_cnt      <= rp_cnt_d;
         state       <= state_d;
         o_inc_pulse <= pulse_d[0];
         o_dec_pulse <= pulse_d[1];
      end
   end
   assign o_held = lvl;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: scoreboard bench; a cycle-level behavioural model predicts
// held levels and pulse times for a repeating and a non-repeating instance.
module tb_button_conditioner;
   localparam int D = 4, RD = 16, RP = 8;
   logic       clk = 1'b0, rst_n = 1'b1, inc_raw = 1'b0, dec_raw = 1'b0;
   logic       inc0, dec0, inc1, dec1;
   logic [1:0] held0, held1;
   int         checks = 0, errors = 0;
   logic [7:0] exp_q[$];
   always #5 clk = ~clk;
   button_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_EN(1'b1)) u0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_increase_duty(inc_raw), .i_decrease_duty(dec_raw),
      .o_inc_pulse(inc0), .o_dec_pulse(dec0), .o_held(held0));
   button_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_EN(1'b0)) u1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_increase_duty(inc_raw), .i_decrease_duty(dec_raw),
      .o_inc_pulse(inc1), .o_dec_pulse(dec1), .o_held(held1));
   // Pulses fall at anchor, anchor+RD, then every RP; an anchor is a press or the end of lockout.
   bit [1:0] d1, d2, held;
   int       run [2];
   int       t = 0, anchor = 0;
   always @(posedge clk) begin : model
      bit [1:0] syn, old, p0, p1;
      int       a, ch;
      p0 = '0;
      p1 = '0;
      if (!rst_n) begin
         d1 = '0; d2 = '0; held = '0; run[0] = 0; run[1] = 0;
      end else begin
         syn = d2;
         d2  = d1;
         d1  = {dec_raw, inc_raw};
         old = held;
         for (int c = 0; c < 2; c++) begin
            run[c] = (syn[c] != held[c]) ? run[c] + 1 : 0;
            if (run[c] == D) begin
               held[c] = syn[c];
               run[c]  = 0;
            end
         end
         if (held == 2'b01 || held == 2'b10) begin
            ch = held[1] ? 1 : 0;
            if (!old[ch]) begin
               anchor = t; p0[ch] = 1'b1; p1[ch] = 1'b1;
            end else if (old == 2'b11) begin
               anchor = t;
            end else begin
               a = t - anchor;
               if (a == RD || (a > RD && (a - RD) % RP == 0)) p0[ch] = 1'b1;
            end
         end
      end
      t++;
      exp_q.push_back({held, p1, held, p0});
   end
   always @(negedge clk) begin : monitor
      logic [7:0] e, g;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = {held1, dec1, inc1, held0, dec0, inc0};
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL outputs at %0t: got held1/dec1/inc1/held0/dec0/inc0=%b expected %b", $time, g, e);
         end
      end
   end
   task automatic check_zero(input string name);
      checks++;
      if ({held1, dec1, inc1, held0, dec0, inc0} !== 8'b0) begin
         errors++;
         $display("FAIL %s: got %b expected 00000000", name, {held1, dec1, inc1, held0, dec0, inc0});
      end
   endtask
   task automatic hold(input bit i, input bit d, input int n);
      inc_raw = i;
      dec_raw = d;
      repeat (n) @(negedge clk);
   endtask
   task automatic pulse_reset();
      #2 rst_n = 1'b0;
      #1 check_zero("async_reset");
      @(negedge clk);
      #2 rst_n = 1'b1;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
   initial begin
      int ci, cd;
      #1 rst_n = 1'b0;
      #1 check_zero("reset_initial");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      hold(0, 0, 5);
      hold(1, 0, 12); hold(0, 0, 20);
      for (int k = 0; k < 10; k++) begin
         hold(0, 1, 2); hold(0, 0, 2);
      end
      hold(0, 0, 10);
      hold(1, 0, 60); hold(0, 0, 20);
      hold(1, 1, 40); hold(0, 1, 30); hold(0, 0, 20);
      hold(1, 0, 40); pulse_reset(); hold(1, 0, 30); hold(0, 0, 20);
      hold(1, 0, 100); hold(0, 0, 20);
      ci = 0;
      cd = 0;
      for (int k = 0; k < 1500; k++) begin
         if (ci == 0) begin
            inc_raw = ~inc_raw;
            ci = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 50);
         end
         if (cd == 0) begin
            dec_raw = ~dec_raw;
            cd = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 50);
         end
         ci--;
         cd--;
         if ($urandom_range(0, 399) == 0) pulse_reset();
         else @(negedge clk);
      end
      hold(0, 0, 30);
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
